dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter_rr_picker.sv | 32 +++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] draddr;
  logic              dwrite;
  logic              dread;
  logic [DATA_W-1:0] dwdata;
  logic [DATA_W-1:0] drdata;

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, drdata,
    output done0, rdata0, done1, rdata1, draddr, dwrite, dread, dwdata
  );

  // Requesters plus memory side
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, drdata,
    input  done0, rdata0, done1, rdata1, draddr, dwrite, dread, dwdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Two-way winner selection. Round-robin when DMEM_ARB_RR_EN is defined,
// otherwise fixed priority with port 0 winning contention.
import dmem_arb_pkg::*;

module rr_picker (
  input  logic cand0_i,
  input  logic cand1_i,
`ifdef DMEM_ARB_RR_EN
  input  logic last_i,
`endif
  output logic valid_o,
  output logic grant_o
);

  // Winner selection among current candidates
  always_comb begin
    valid_o = cand0_i | cand1_i;
    grant_o = PORT_CPU;
    if (cand0_i && cand1_i) begin
`ifdef DMEM_ARB_RR_EN
      grant_o = ~last_i;
`else
      grant_o = PORT_CPU;
`endif
    end else if (cand1_i) begin
      grant_o = PORT_DBG;
    end else begin
      grant_o = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one memory access per BUSY cycle, the owner of
// the current cycle is excluded from the next arbitration. Option: DMEM_ARB_RR_EN.
import dmem_arb_pkg::*;

module dmem_arbiter (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] draddr_q, draddr_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic              dwrite_q, dwrite_d;
  logic              dread_q, dread_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              cand0, cand1, grant_valid, grant;
`ifdef DMEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  assign cand0 = bus.req0 && (state_q != ST_BUSY0);
  assign cand1 = bus.req1 && (state_q != ST_BUSY1);

  rr_picker u_picker (
    .cand0_i (cand0),
    .cand1_i (cand1),
`ifdef DMEM_ARB_RR_EN
    .last_i  (last_q),
`endif
    .valid_o (grant_valid),
    .grant_o (grant)
  );

  // Next state, latched access for the next cycle, read-data capture
  always_comb begin
    state_d  = ST_IDLE;
    draddr_d = '0;
    dwdata_d = '0;
    dwrite_d = 1'b0;
    dread_d  = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_d   = last_q;
`endif
    if (grant_valid) begin
`ifdef DMEM_ARB_RR_EN
      last_d = grant;
`endif
      case (grant)
        PORT_CPU: begin
          state_d  = ST_BUSY0;
          draddr_d = bus.addr0;
          dwdata_d = bus.wdata0;
          dwrite_d = bus.we0;
          dread_d  = ~bus.we0;
          done0_d  = 1'b1;
        end
        PORT_DBG: begin
          state_d  = ST_BUSY1;
          draddr_d = bus.addr1;
          dwdata_d = bus.wdata1;
          dwrite_d = bus.we1;
          dread_d  = ~bus.we1;
          done1_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = ST_IDLE;
    end

    // Read data is visible during the read cycle itself, then held
    if ((state_q == ST_BUSY0) && dread_q) begin
      rdata0_d = bus.drdata;
    end else begin
      rdata0_d = rdata0_q;
    end
    if ((state_q == ST_BUSY1) && dread_q) begin
      rdata1_d = bus.drdata;
    end else begin
      rdata1_d = rdata1_q;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      draddr_q <= '0;
      dwdata_q <= '0;
      dwrite_q <= 1'b0;
      dread_q  <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q   <= PORT_DBG;
`endif
    end else begin
      state_q  <= state_d;
      draddr_q <= draddr_d;
      dwdata_q <= dwdata_d;
      dwrite_q <= dwrite_d;
      dread_q  <= dread_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.draddr = draddr_q;
  assign bus.dwdata = dwdata_q;
  assign bus.dwrite = dwrite_q;
  assign bus.dread  = dread_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.rdata0 = rdata0_d;
  assign bus.rdata1 = rdata1_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [15:0] mem [0:255];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read, write at the edge ending a write cycle; reset preloads 0x0004
  assign bus.drdata = mem[bus.draddr[7:0]];
  always @(posedge clk) begin
    if (rst) mem[8'h04] <= 16'h1234;
    else if (bus.dwrite) mem[bus.draddr[7:0]] <= bus.dwdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 16'h0000; bus.wdata0 = 16'h0000;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 16'h0000; bus.wdata1 = 16'h0000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle_bus();
    step();
    step();

    // Reset state
    check("rst_done0", {31'd0, bus.done0}, 32'd0);
    check("rst_done1", {31'd0, bus.done1}, 32'd0);
    check("rst_rdata0", {16'd0, bus.rdata0}, 32'd0);
    check("rst_rdata1", {16'd0, bus.rdata1}, 32'd0);
    check("rst_dread", {31'd0, bus.dread}, 32'd0);
    check("rst_dwrite", {31'd0, bus.dwrite}, 32'd0);
    check("rst_draddr", {16'd0, bus.draddr}, 32'd0);

    // Port 0 read of 0x0004
    rst = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0004;
    step();
    check("rd0_dread", {31'd0, bus.dread}, 32'd1);
    check("rd0_dwrite", {31'd0, bus.dwrite}, 32'd0);
    check("rd0_draddr", {16'd0, bus.draddr}, 32'h0004);
    check("rd0_done0", {31'd0, bus.done0}, 32'd1);
    check("rd0_rdata0", {16'd0, bus.rdata0}, 32'h1234);
    bus.req0 = 1'b0;
    step();
    check("rd0_idle_done0", {31'd0, bus.done0}, 32'd0);
    check("rd0_hold_rdata0", {16'd0, bus.rdata0}, 32'h1234);
    check("rd0_idle_draddr", {16'd0, bus.draddr}, 32'd0);
    check("rd0_idle_dread", {31'd0, bus.dread}, 32'd0);

    // Port 1 write 0xBEEF to 0x00A0, then read back through port 0
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h00A0; bus.wdata1 = 16'hBEEF;
    step();
    check("wr1_dwrite", {31'd0, bus.dwrite}, 32'd1);
    check("wr1_dread", {31'd0, bus.dread}, 32'd0);
    check("wr1_draddr", {16'd0, bus.draddr}, 32'h00A0);
    check("wr1_dwdata", {16'd0, bus.dwdata}, 32'hBEEF);
    check("wr1_done1", {31'd0, bus.done1}, 32'd1);
    bus.req1 = 1'b0;
    step();
    check("wr1_end_dwrite", {31'd0, bus.dwrite}, 32'd0);
    check("wr1_end_done1", {31'd0, bus.done1}, 32'd0);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h00A0;
    step();
    check("rb0_done0", {31'd0, bus.done0}, 32'd1);
    check("rb0_rdata0", {16'd0, bus.rdata0}, 32'hBEEF);
    bus.req0 = 1'b0;
    step();

    // Contention straight after reset: port 0 first, port 1 in the very next cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0004;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h00A0;
    step();
    check("both_first_done0", {31'd0, bus.done0}, 32'd1);
    check("both_first_done1", {31'd0, bus.done1}, 32'd0);
    bus.req0 = 1'b0;
    step();
    check("both_second_done1", {31'd0, bus.done1}, 32'd1);
    check("both_second_done0", {31'd0, bus.done0}, 32'd0);
    check("both_second_rdata1", {16'd0, bus.rdata1}, 32'hBEEF);
    bus.req1 = 1'b0;
    step();

    // Contention after port 0 was last served: policy decides
    bus.req0 = 1'b1;
    step();
    bus.req0 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
`ifdef DMEM_ARB_RR_EN
    check("policy_done1", {31'd0, bus.done1}, 32'd1);
    check("policy_done0", {31'd0, bus.done0}, 32'd0);
`else
    check("policy_done1", {31'd0, bus.done1}, 32'd0);
    check("policy_done0", {31'd0, bus.done0}, 32'd1);
`endif
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();

    // req0 held: done0 every second cycle
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0004;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("hold_done0_%0d", i), {31'd0, bus.done0}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.req0 = 1'b0;
    step();

    // Reset during a port 1 write
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0030; bus.wdata1 = 16'h5555;
    step();
    check("rstw_dwrite_pre", {31'd0, bus.dwrite}, 32'd1);
    rst = 1'b1;
    step();
    check("rstw_dwrite", {31'd0, bus.dwrite}, 32'd0);
    check("rstw_done1", {31'd0, bus.done1}, 32'd0);
    check("rstw_rdata0", {16'd0, bus.rdata0}, 32'd0);
    check("rstw_rdata1", {16'd0, bus.rdata1}, 32'd0);
    rst = 1'b0;
    bus.req1 = 1'b0;
    step();

    // Same-address writes from both ports: port 1 granted last, its data stays
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 16'h1111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0010; bus.wdata1 = 16'h2222;
    step();
    check("ww_first_done0", {31'd0, bus.done0}, 32'd1);
    check("ww_first_dwdata", {16'd0, bus.dwdata}, 32'h1111);
    bus.req0 = 1'b0;
    step();
    check("ww_second_done1", {31'd0, bus.done1}, 32'd1);
    check("ww_second_dwdata", {16'd0, bus.dwdata}, 32'h2222);
    bus.req1 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    step();
    check("ww_readback", {16'd0, bus.rdata0}, 32'h2222);
    bus.req0 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
